// File: rtl/stream_hsmooth.sv
// Horizontal [1 2 1]/4 per-channel smoother for 24-bit RGB video; optional stats via STREAM_HSMOOTH_STATS_EN.
// Latency: pixel x emitted the cycle after pixel x+1 is accepted; row-end flush and pass-through beats take 1 cycle.
// Backpressure: single output register; sink_ready drops when the output is held or during the 1-cycle row flush.
module stream_hsmooth #(
  parameter logic [10:0] IMAGE_W    = 11'd640,
  parameter int          DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  filter_en,
  input  logic [DATA_WIDTH-1:0] sink_data,
  input  logic                  sink_valid,
  output logic                  sink_ready,
  input  logic                  sink_sop,
  input  logic                  sink_eop,
  output logic [DATA_WIDTH-1:0] source_data,
  output logic                  source_valid,
  input  logic                  source_ready,
  output logic                  source_sop,
  output logic                  source_eop
`ifdef STREAM_HSMOOTH_STATS_EN
  ,
  output logic [15:0]           frame_count,
  output logic                  row_error
`endif
);

  typedef enum logic [2:0] {IDLE, PASS, FILL, RUN, FLUSH} state_t;

  state_t                state, state_d;
  logic [10:0]           x, x_d;
  logic [DATA_WIDTH-1:0] prev, prev_d, cur, cur_d;
  logic                  flush_eop, flush_eop_d;
  logic                  pend_sop, pend_sop_d;
  logic                  pend_video, pend_video_d;
  logic                  out_vld_d, out_sop_d, out_eop_d;
  logic [DATA_WIDTH-1:0] out_dat_d;
  logic                  out_free, accept, is_video;

  function automatic logic [DATA_WIDTH-1:0] smooth(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b,
                                                   input logic [DATA_WIDTH-1:0] c);
    logic [DATA_WIDTH-1:0] r;
    logic [9:0]            s;
    r = '0;
    for (int ch = 0; ch < DATA_WIDTH / 8; ch++) begin
      s = {2'b00, a[ch*8 +: 8]} + {1'b0, b[ch*8 +: 8], 1'b0} + {2'b00, c[ch*8 +: 8]};
      r[ch*8 +: 8] = 8'(s >> 2);
    end
    return r;
  endfunction

  assign out_free   = ~source_valid | source_ready;
  assign sink_ready = out_free & (state != FLUSH);
  assign accept     = sink_valid & sink_ready;
  assign is_video   = (sink_data[3:0] == 4'h0) & filter_en;

  always_comb begin
    state_d      = state;
    x_d          = x;
    prev_d       = prev;
    cur_d        = cur;
    flush_eop_d  = flush_eop;
    pend_sop_d   = pend_sop;
    pend_video_d = pend_video;
    out_vld_d    = source_valid & ~source_ready;
    out_dat_d    = source_data;
    out_sop_d    = source_sop;
    out_eop_d    = source_eop;

    // A sop outside RUN has no held pixel to flush, so it starts a new packet directly
    if (accept && sink_sop && state != RUN) begin
      out_vld_d = 1'b1;
      out_dat_d = sink_data;
      out_sop_d = 1'b1;
      out_eop_d = sink_eop;
      x_d       = '0;
      if (sink_eop)      state_d = IDLE;
      else if (is_video) state_d = FILL;
      else               state_d = PASS;
    end else begin
      case (state)
        PASS: if (accept) begin
          out_vld_d = 1'b1;
          out_dat_d = sink_data;
          out_sop_d = 1'b0;
          out_eop_d = sink_eop;
          if (sink_eop) state_d = IDLE;
        end
        FILL: if (accept) begin
          prev_d = sink_data;
          cur_d  = sink_data;
          x_d    = 11'd1;
          if (sink_eop || IMAGE_W == 11'd1) begin
            flush_eop_d = sink_eop;
            state_d     = FLUSH;
          end else begin
            state_d = RUN;
          end
        end
        RUN: if (accept) begin
          out_vld_d = 1'b1;
          out_sop_d = 1'b0;
          out_eop_d = 1'b0;
          if (sink_sop) begin
            // Abort: close the row now, park the new sop word in cur and replay it from FLUSH
            out_dat_d    = smooth(prev, cur, cur);
            cur_d        = sink_data;
            pend_sop_d   = 1'b1;
            pend_video_d = is_video;
            flush_eop_d  = sink_eop;
            state_d      = FLUSH;
          end else begin
            out_dat_d = smooth(prev, cur, sink_data);
            prev_d    = cur;
            cur_d     = sink_data;
            x_d       = x + 11'd1;
            if (x == IMAGE_W - 11'd1 || sink_eop) begin
              flush_eop_d = sink_eop;
              state_d     = FLUSH;
            end
          end
        end
        FLUSH: if (out_free) begin
          out_vld_d = 1'b1;
          out_eop_d = flush_eop;
          x_d       = '0;
          if (pend_sop) begin
            out_dat_d  = cur;
            out_sop_d  = 1'b1;
            pend_sop_d = 1'b0;
            if (flush_eop)       state_d = IDLE;
            else if (pend_video) state_d = FILL;
            else                 state_d = PASS;
          end else begin
            out_dat_d = smooth(prev, cur, cur);
            out_sop_d = 1'b0;
            state_d   = flush_eop ? IDLE : FILL;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      x            <= '0;
      prev         <= '0;
      cur          <= '0;
      flush_eop    <= 1'b0;
      pend_sop     <= 1'b0;
      pend_video   <= 1'b0;
      source_valid <= 1'b0;
      source_data  <= '0;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
    end else begin
      state        <= state_d;
      x            <= x_d;
      prev         <= prev_d;
      cur          <= cur_d;
      flush_eop    <= flush_eop_d;
      pend_sop     <= pend_sop_d;
      pend_video   <= pend_video_d;
      source_valid <= out_vld_d;
      source_data  <= out_dat_d;
      source_sop   <= out_sop_d;
      source_eop   <= out_eop_d;
    end
  end

`ifdef STREAM_HSMOOTH_STATS_EN
  logic frame_end, row_err_d;

  // x still holds pixels-in-row during the final flush; anything short of IMAGE_W is a partial row
  always_comb begin
    frame_end = (state == FLUSH) & out_free & ~pend_sop & flush_eop;
    row_err_d = (frame_end & (x != IMAGE_W)) |
                (accept & sink_sop & ((state == FILL) | (state == RUN)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count <= '0;
      row_error   <= 1'b0;
    end else begin
      if (frame_end) frame_count <= frame_count + 16'd1;
      row_error <= row_err_d;
    end
  end
`endif

endmodule

// File: tb/tb_stream_hsmooth.sv
// Directed bench for stream_hsmooth with IMAGE_W=4: filtering, bypass, pass-through, backpressure, reset, aborts.
module tb_stream_hsmooth;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        filter_en = 1'b1;
  logic [23:0] sink_data = '0;
  logic        sink_valid = 1'b0, sink_sop = 1'b0, sink_eop = 1'b0;
  logic        sink_ready;
  logic [23:0] source_data;
  logic        source_valid, source_sop, source_eop;
  logic        source_ready = 1'b1;

  stream_hsmooth #(.IMAGE_W(11'd4)) dut (
    .clk(clk), .reset(reset), .filter_en(filter_en),
    .sink_data(sink_data), .sink_valid(sink_valid), .sink_ready(sink_ready),
    .sink_sop(sink_sop), .sink_eop(sink_eop),
    .source_data(source_data), .source_valid(source_valid), .source_ready(source_ready),
    .source_sop(source_sop), .source_eop(source_eop)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int cyc = 0, lowcnt = 0, acc_cyc = 0, rd_idx = 0;
  int hold_n = 0, hold_bad = 0;
  logic        bp_mode = 1'b0;
  logic [3:0]  bp_seq = 4'b1001;
  int          bp_i = 0;
  logic        stalled_prev = 1'b0;
  logic [25:0] held = '0;
  logic [25:0] cap_q[$];
  int          cap_cyc[$];
  logic [25:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [25:0] bt(input logic s, input logic e, input logic [23:0] d);
    return {s, e, d};
  endfunction

  function automatic int cyc_at(input int i);
    return (i < cap_cyc.size()) ? cap_cyc[i] : -1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && !sink_ready) lowcnt <= lowcnt + 1;
    if (!reset && source_valid && source_ready) begin
      cap_q.push_back({source_sop, source_eop, source_data});
      cap_cyc.push_back(cyc);
    end
    if (!reset && stalled_prev) begin
      hold_n <= hold_n + 1;
      if (!source_valid || {source_sop, source_eop, source_data} !== held) hold_bad <= hold_bad + 1;
    end
    stalled_prev <= source_valid && !source_ready && !reset;
    held         <= {source_sop, source_eop, source_data};
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (bp_mode) begin
        source_ready = bp_seq[bp_i];
        bp_i = (bp_i + 1) % 4;
      end else begin
        source_ready = 1'b1;
      end
    end
  end

  task automatic send(input logic [23:0] d, input logic s, input logic e);
    int guard = 0;
    @(negedge clk);
    sink_data = d; sink_sop = s; sink_eop = e; sink_valid = 1'b1;
    #1;
    while (!sink_ready && guard < 100) begin
      @(negedge clk); #1; guard++;
    end
    if (guard >= 100) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
  endtask

  task automatic idle_in();
    @(negedge clk);
    sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
  endtask

  task automatic expect_out(input string name);
    int guard = 0;
    while (cap_q.size() < rd_idx + exp_q.size() && guard < 200) begin
      @(posedge clk); guard++;
    end
    repeat (4) @(posedge clk);
    chk({name, "_count"}, 32'(cap_q.size() - rd_idx), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (rd_idx + i < cap_q.size())
        chk($sformatf("%s_beat%0d", name, i), 32'(cap_q[rd_idx + i]), 32'(exp_q[i]));
      else
        chk($sformatf("%s_beat%0d_missing", name, i), 32'hDEAD_BEEF, 32'(exp_q[i]));
    end
    rd_idx = cap_q.size();
    exp_q = {};
  endtask

  task automatic send_ramp_row();
    send(24'h000000, 1'b1, 1'b0);
    send(24'h000000, 1'b0, 1'b0);
    send(24'h640000, 1'b0, 1'b0);
    send(24'hC80000, 1'b0, 1'b0);
    send(24'h280000, 1'b0, 1'b1);
  endtask

  task automatic push_ramp_filtered();
    exp_q = '{bt(1'b1, 1'b0, 24'h000000), bt(1'b0, 1'b0, 24'h190000), bt(1'b0, 1'b0, 24'h640000),
              bt(1'b0, 1'b0, 24'h870000), bt(1'b0, 1'b1, 24'h500000)};
  endtask

  initial begin
    int l0, base, a_last;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_source_valid", 32'(source_valid), 32'd0);
    chk("rst_source_data",  32'(source_data),  32'd0);
    chk("rst_source_sop",   32'(source_sop),   32'd0);
    chk("rst_source_eop",   32'(source_eop),   32'd0);
    chk("rst_sink_ready",   32'(sink_ready),   32'd1);
    reset = 1'b0;

    // Filtered row: R 0,100,200,40 -> 25,100,135,80
    filter_en = 1'b1;
    l0 = lowcnt; base = rd_idx;
    send_ramp_row();
    a_last = acc_cyc;
    idle_in();
    push_ramp_filtered();
    expect_out("video_row");
    chk("video_row_stall_cycles", 32'(lowcnt - l0), 32'd1);
    chk("video_last_latency", 32'(cyc_at(base + 4)), 32'(a_last + 1));

    // Bypass via filter_en=0 at sop
    filter_en = 1'b0;
    l0 = lowcnt; base = rd_idx;
    send_ramp_row();
    a_last = acc_cyc;
    idle_in();
    filter_en = 1'b1;
    exp_q = '{bt(1'b1, 1'b0, 24'h000000), bt(1'b0, 1'b0, 24'h000000), bt(1'b0, 1'b0, 24'h640000),
              bt(1'b0, 1'b0, 24'hC80000), bt(1'b0, 1'b1, 24'h280000)};
    expect_out("bypass");
    chk("bypass_stall_cycles", 32'(lowcnt - l0), 32'd0);
    chk("bypass_latency", 32'(cyc_at(base + 4)), 32'(a_last));

    // Non-video packet forwarded unchanged despite filter_en=1
    send(24'h00000F, 1'b1, 1'b0);
    send(24'h123456, 1'b0, 1'b0);
    send(24'h123456, 1'b0, 1'b0);
    send(24'h123456, 1'b0, 1'b1);
    idle_in();
    exp_q = '{bt(1'b1, 1'b0, 24'h00000F), bt(1'b0, 1'b0, 24'h123456),
              bt(1'b0, 1'b0, 24'h123456), bt(1'b0, 1'b1, 24'h123456)};
    expect_out("nonvideo");

    // White row under toggling backpressure
    bp_mode = 1'b1;
    send(24'h000000, 1'b1, 1'b0);
    send(24'hFFFFFF, 1'b0, 1'b0);
    send(24'hFFFFFF, 1'b0, 1'b0);
    send(24'hFFFFFF, 1'b0, 1'b0);
    send(24'hFFFFFF, 1'b0, 1'b1);
    idle_in();
    exp_q = '{bt(1'b1, 1'b0, 24'h000000), bt(1'b0, 1'b0, 24'hFFFFFF), bt(1'b0, 1'b0, 24'hFFFFFF),
              bt(1'b0, 1'b0, 24'hFFFFFF), bt(1'b0, 1'b1, 24'hFFFFFF)};
    expect_out("white_bp");
    bp_mode = 1'b0;
    repeat (2) @(posedge clk);
    chk("hold_stable_violations", 32'(hold_bad), 32'd0);
    chk("hold_stalls_seen", 32'(hold_n > 0), 32'd1);

    // Reset mid-row, then a clean packet
    send(24'h000000, 1'b1, 1'b0);
    send(24'h100000, 1'b0, 1'b0);
    send(24'h200000, 1'b0, 1'b0);
    @(negedge clk);
    sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("midrow_reset_valid", 32'(source_valid), 32'd0);
    reset = 1'b0;
    rd_idx = cap_q.size();
    send_ramp_row();
    idle_in();
    push_ramp_filtered();
    expect_out("after_reset");

    // Single-pixel packet passes the pixel through unchanged
    send(24'h000000, 1'b1, 1'b0);
    send(24'h804020, 1'b0, 1'b1);
    idle_in();
    exp_q = '{bt(1'b1, 1'b0, 24'h000000), bt(1'b0, 1'b1, 24'h804020)};
    expect_out("single_pixel");

    // sop arriving mid-row: held pixel flushed without eop, new sop forwarded
    send(24'h000000, 1'b1, 1'b0);
    send(24'h040000, 1'b0, 1'b0);
    send(24'h080000, 1'b0, 1'b0);
    send(24'h00000F, 1'b1, 1'b1);
    idle_in();
    exp_q = '{bt(1'b1, 1'b0, 24'h000000), bt(1'b0, 1'b0, 24'h050000),
              bt(1'b0, 1'b0, 24'h070000), bt(1'b1, 1'b1, 24'h00000F)};
    expect_out("sop_abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
